// File: rtl/axi_burst_mem.sv
// axi_burst_mem: AXI4 slave memory; independent AW/W/B and AR/R burst engines share one byte-lane RAM.
// Define AXI_BURST_MEM_RD_PIPE_EN to add an output register stage with a 2-entry buffer on the read path.
module axi_burst_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int LANE_BITS = $clog2(STRB_WIDTH);
    localparam int WORD_AW   = ADDR_WIDTH - LANE_BITS;
    localparam int DEPTH     = 1 << WORD_AW;
    localparam logic [2:0] MAX_SIZE = 3'(LANE_BITS);

    typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_BURST} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t              w_state, w_state_next;
    r_state_t              r_state, r_state_next;
    logic                  ready_en;
    logic                  aw_fire, w_fire, ar_fire, r_issue;
    logic [ID_WIDTH-1:0]   w_id, r_id;
    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic [7:0]            w_len, r_len, w_count;
    logic [2:0]            w_size, r_size;
    logic [1:0]            w_burst, r_burst;
    logic [8:0]            r_remain;
    logic [WORD_AW-1:0]    w_word, r_word;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot};

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > MAX_SIZE) ? MAX_SIZE : size;
    endfunction

    // WRAP bursts stay inside a (len+1)<<size window aligned down from the start address.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst,
                                                        input logic [7:0] len);
        logic [ADDR_WIDTH-1:0] step, mask, result;
        step = ADDR_WIDTH'(1) << size;
        mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   result = addr;
            2'b10:   result = (addr & ~mask) | ((addr + step) & mask);
            default: result = addr + step;
        endcase
        return result;
    endfunction

    assign w_word  = w_addr[ADDR_WIDTH-1:LANE_BITS];
    assign r_word  = r_addr[ADDR_WIDTH-1:LANE_BITS];
    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid && s_axi_wready;
    assign ar_fire = s_axi_arvalid && s_axi_arready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            ready_en <= 1'b0;
        end else begin
            w_state  <= w_state_next;
            r_state  <= r_state_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        w_state_next  = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = ready_en;
                if (s_axi_awvalid && ready_en) w_state_next = W_BURST;
            end
            W_BURST: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_count == 8'd0) w_state_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign s_axi_bid   = w_id;
    assign s_axi_bresp = 2'b00;

    // Burst length is taken from awlen; wlast is not consulted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_count <= '0;
        end else if (aw_fire) begin
            w_id    <= s_axi_awid;
            w_addr  <= s_axi_awaddr;
            w_len   <= s_axi_awlen;
            w_size  <= clamp_size(s_axi_awsize);
            w_burst <= s_axi_awburst;
            w_count <= s_axi_awlen;
        end else if (w_fire) begin
            w_addr  <= next_addr(w_addr, w_size, w_burst, w_len);
            w_count <= w_count - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) mem[w_word][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        r_state_next  = r_state;
        s_axi_arready = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = ready_en;
                if (s_axi_arvalid && ready_en) r_state_next = R_BURST;
            end
            R_BURST: begin
                if (s_axi_rvalid && s_axi_rready && s_axi_rlast) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign s_axi_rid   = r_id;
    assign s_axi_rresp = 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_remain <= '0;
        end else if (ar_fire) begin
            r_id     <= s_axi_arid;
            r_addr   <= s_axi_araddr;
            r_len    <= s_axi_arlen;
            r_size   <= clamp_size(s_axi_arsize);
            r_burst  <= s_axi_arburst;
            r_remain <= {1'b0, s_axi_arlen} + 9'd1;
        end else if (r_issue) begin
            r_addr   <= next_addr(r_addr, r_size, r_burst, r_len);
            r_remain <= r_remain - 9'd1;
        end
    end

`ifdef AXI_BURST_MEM_RD_PIPE_EN
    logic                  s1_valid, s1_last, q_pop;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [DATA_WIDTH:0]   q0, q1;
    logic [1:0]            q_count, q_after_pop;

    // Issue only when the RAM stage plus buffer can still hold the beat, so stalls never drop data.
    assign q_pop       = (q_count != 2'd0) && s_axi_rready;
    assign q_after_pop = q_count - {1'b0, q_pop};
    assign r_issue     = (r_state == R_BURST) && (r_remain != 9'd0) &&
                         ((q_after_pop + {1'b0, s1_valid}) < 2'd2);

    assign s_axi_rvalid = (q_count != 2'd0);
    assign s_axi_rdata  = q0[DATA_WIDTH-1:0];
    assign s_axi_rlast  = q0[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            q0       <= '0;
            q1       <= '0;
            q_count  <= 2'd0;
        end else begin
            s1_valid <= r_issue;
            if (r_issue) begin
                s1_data <= mem[r_word];
                s1_last <= (r_remain == 9'd1);
            end
            if (q_pop) q0 <= q1;
            if (s1_valid) begin
                if (q_after_pop == 2'd0) q0 <= {s1_last, s1_data};
                else                     q1 <= {s1_last, s1_data};
            end
            q_count <= q_after_pop + {1'b0, s1_valid};
        end
    end
`else
    logic                  rvalid_q, rlast_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign r_issue = (r_state == R_BURST) && (r_remain != 9'd0) && (!rvalid_q || s_axi_rready);

    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rlast  = rlast_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
        end else if (r_issue) begin
            rvalid_q <= 1'b1;
            rdata_q  <= mem[r_word];
            rlast_q  <= (r_remain == 9'd1);
        end else if (s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_axi_burst_mem.sv
// tb_axi_burst_mem: table-driven single-beat vectors plus hand-written burst sequences, with a read scoreboard.
`timescale 1ns/1ps
module tb_axi_burst_mem;
`ifdef AXI_BURST_MEM_RD_PIPE_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axi_awid = '0, s_axi_arid = '0;
    logic [15:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
    logic [2:0]  s_axi_awsize = '0, s_axi_arsize = '0;
    logic [1:0]  s_axi_awburst = '0, s_axi_arburst = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic        s_axi_awready, s_axi_arready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
    logic [7:0]  s_axi_bid, s_axi_rid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready = 1'b0;
    logic [31:0] s_axi_rdata;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;

    int n_compared = 0;
    int n_mismatched = 0;
    int cycle = 0;
    int wf, wl, rf, rl, beats, guard;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] prefill;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vectors [6];
    logic [32:0] rd_expect_q [$];

    axi_burst_mem dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushIncr(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) rd_expect_q.push_back({(i == n - 1), base + 32'(i)});
    endtask

    task automatic writeBurst(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [7:0] id, input logic [31:0] base,
                              input logic [3:0] strb, input int bready_delay,
                              output int first_cyc, output int last_cyc);
        int g, nb;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        g = 0;
        while (s_axi_awready !== 1'b1 && g < 100) begin @(posedge clk); #1; g++; end
        checkOutput("aw_handshake_in_time", 64'(g < 100), 64'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        nb = 0; g = 0; first_cyc = -1; last_cyc = -1;
        s_axi_wvalid = 1'b1;
        while (nb <= int'(len) && g < 300) begin
            s_axi_wdata = base + 32'(nb);
            s_axi_wstrb = strb;
            s_axi_wlast = (nb == int'(len));
            if (s_axi_wready === 1'b1) begin
                if (first_cyc < 0) first_cyc = cycle;
                last_cyc = cycle;
                nb++;
            end
            @(posedge clk); #1; g++;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        checkOutput("w_beats_accepted", 64'(nb), 64'(int'(len) + 1));
        for (int i = 0; i < bready_delay; i++) begin
            checkOutput("bvalid_held_while_bready_low", 64'(s_axi_bvalid), 64'd1);
            checkOutput("awready_low_until_b", 64'(s_axi_awready), 64'd0);
            @(posedge clk); #1;
        end
        s_axi_bready = 1'b1;
        g = 0;
        while (s_axi_bvalid !== 1'b1 && g < 100) begin @(posedge clk); #1; g++; end
        checkOutput("bvalid", 64'(s_axi_bvalid), 64'd1);
        checkOutput("bid", 64'(s_axi_bid), 64'(id));
        checkOutput("bresp", 64'(s_axi_bresp), 64'd0);
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        checkOutput("bvalid_cleared_after_b", 64'(s_axi_bvalid), 64'd0);
        checkOutput("awready_after_b", 64'(s_axi_awready), 64'd1);
    endtask

    // Beats are checked against expectations the caller pushed into rd_expect_q.
    task automatic readBurst(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [7:0] id, input bit toggle,
                             output int first_cyc, output int last_cyc);
        int g, nb, since_ar, first_valid;
        bit held;
        logic [31:0] held_data;
        logic        held_last;
        logic [32:0] exp;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        g = 0;
        while (s_axi_arready !== 1'b1 && g < 100) begin @(posedge clk); #1; g++; end
        checkOutput("ar_handshake_in_time", 64'(g < 100), 64'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        nb = 0; since_ar = 0; first_valid = -1; held = 1'b0;
        first_cyc = -1; last_cyc = -1;
        held_data = '0; held_last = 1'b0;
        while (nb <= int'(len) && since_ar < 400) begin
            s_axi_rready = toggle ? since_ar[0] : 1'b1;
            if (held) begin
                checkOutput("rvalid_held_during_stall", 64'(s_axi_rvalid), 64'd1);
                checkOutput("rdata_stable_during_stall", 64'(s_axi_rdata), 64'(held_data));
                checkOutput("rlast_stable_during_stall", 64'(s_axi_rlast), 64'(held_last));
                held = 1'b0;
            end
            if (s_axi_rvalid === 1'b1) begin
                if (first_valid < 0) first_valid = since_ar;
                if (s_axi_rready) begin
                    if (first_cyc < 0) first_cyc = cycle;
                    last_cyc = cycle;
                    if (rd_expect_q.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL r_unexpected_beat: got data 0x%0h, expected no beat", s_axi_rdata);
                    end else begin
                        exp = rd_expect_q.pop_front();
                        checkOutput("rdata", 64'(s_axi_rdata), 64'(exp[31:0]));
                        checkOutput("rlast", 64'(s_axi_rlast), 64'(exp[32]));
                        checkOutput("rid", 64'(s_axi_rid), 64'(id));
                        checkOutput("rresp", 64'(s_axi_rresp), 64'd0);
                    end
                    nb++;
                end else begin
                    held = 1'b1;
                    held_data = s_axi_rdata;
                    held_last = s_axi_rlast;
                end
            end
            @(posedge clk); #1; since_ar++;
        end
        s_axi_rready = 1'b0;
        checkOutput("r_beats_received", 64'(nb), 64'(int'(len) + 1));
        checkOutput("r_first_beat_latency", 64'(first_valid), 64'(RD_LAT));
        checkOutput("arready_after_last_r", 64'(s_axi_arready), 64'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int f, l;
        writeBurst(v.addr, 8'd0, 3'd2, INCR, 8'h10, v.prefill, 4'hF, 0, f, l);
        writeBurst(v.addr, 8'd0, 3'd2, INCR, 8'h11, v.wdata, v.wstrb, 0, f, l);
        rd_expect_q.push_back({1'b1, v.exp_data});
        readBurst(v.addr & 16'hFFFC, 8'd0, 3'd2, INCR, 8'h12, 1'b0, f, l);
    endtask

    initial begin
        vectors[0] = '{16'h0200, 32'hFFFF_FFFF, 32'h1122_3344, 4'h5, 32'hFF22_FF44};
        vectors[1] = '{16'h0204, 32'hFFFF_FFFF, 32'h1122_3344, 4'hA, 32'h11FF_33FF};
        vectors[2] = '{16'h0208, 32'h0000_0000, 32'hAABB_CCDD, 4'h1, 32'h0000_00DD};
        vectors[3] = '{16'h020C, 32'h1234_5678, 32'hCAFE_F00D, 4'h0, 32'h1234_5678};
        vectors[4] = '{16'h0212, 32'h0000_0000, 32'h1122_3344, 4'hC, 32'h1122_0000};
        vectors[5] = '{16'hFFFC, 32'h0000_0000, 32'h89AB_CDEF, 4'hF, 32'h89AB_CDEF};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_awready", 64'(s_axi_awready), 64'd0);
        checkOutput("reset_arready", 64'(s_axi_arready), 64'd0);
        checkOutput("reset_wready", 64'(s_axi_wready), 64'd0);
        checkOutput("reset_bvalid", 64'(s_axi_bvalid), 64'd0);
        checkOutput("reset_rvalid_rlast", 64'({s_axi_rvalid, s_axi_rlast}), 64'd0);
        checkOutput("reset_ids_resps", 64'({s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp}), 64'd0);
        checkOutput("reset_rdata", 64'(s_axi_rdata), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("arready_low_before_first_edge", 64'(s_axi_arready), 64'd0);
        @(posedge clk); #1;
        checkOutput("awready_after_reset", 64'(s_axi_awready), 64'd1);
        checkOutput("arready_after_reset", 64'(s_axi_arready), 64'd1);

        $display("[TB] single write / read");
        writeBurst(16'h0010, 8'd0, 3'd2, INCR, 8'h5A, 32'hDEAD_BEEF, 4'hF, 0, wf, wl);
        rd_expect_q.push_back({1'b1, 32'hDEAD_BEEF});
        readBurst(16'h0010, 8'd0, 3'd2, INCR, 8'h3C, 1'b0, rf, rl);

        $display("[TB] byte-strobe vectors");
        for (int i = 0; i < 6; i++) applyStimulus(vectors[i]);

        $display("[TB] INCR 16-beat burst with rready toggling");
        writeBurst(16'h0100, 8'd15, 3'd2, INCR, 8'h01, 32'd0, 4'hF, 0, wf, wl);
        pushIncr(32'd0, 16);
        readBurst(16'h0100, 8'd15, 3'd2, INCR, 8'h02, 1'b1, rf, rl);

        $display("[TB] WRAP read and FIXED write");
        writeBurst(16'h0030, 8'd3, 3'd2, INCR, 8'h03, 32'hA0, 4'hF, 0, wf, wl);
        rd_expect_q.push_back({1'b0, 32'hA2});
        rd_expect_q.push_back({1'b0, 32'hA3});
        rd_expect_q.push_back({1'b0, 32'hA0});
        rd_expect_q.push_back({1'b1, 32'hA1});
        readBurst(16'h0038, 8'd3, 3'd2, WRAP, 8'h04, 1'b0, rf, rl);
        writeBurst(16'h0044, 8'd0, 3'd2, INCR, 8'h05, 32'h1234_5678, 4'hF, 0, wf, wl);
        writeBurst(16'h0040, 8'd3, 3'd2, FIXED, 8'h06, 32'hF0, 4'hF, 0, wf, wl);
        rd_expect_q.push_back({1'b0, 32'hF3});
        rd_expect_q.push_back({1'b1, 32'h1234_5678});
        readBurst(16'h0040, 8'd1, 3'd2, INCR, 8'h07, 1'b0, rf, rl);

        $display("[TB] size clamp, burst=11, address wrap-around");
        writeBurst(16'h0300, 8'd1, 3'd3, INCR, 8'h08, 32'h300, 4'hF, 0, wf, wl);
        pushIncr(32'h300, 2);
        readBurst(16'h0300, 8'd1, 3'd2, INCR, 8'h09, 1'b0, rf, rl);
        pushIncr(32'd0, 4);
        readBurst(16'h0100, 8'd3, 3'd2, 2'b11, 8'h0A, 1'b0, rf, rl);
        writeBurst(16'hFFFC, 8'd1, 3'd2, INCR, 8'h0B, 32'h5000, 4'hF, 0, wf, wl);
        pushIncr(32'h5000, 2);
        readBurst(16'hFFFC, 8'd1, 3'd2, INCR, 8'h0C, 1'b0, rf, rl);

        $display("[TB] concurrent read and write bursts");
        writeBurst(16'h0400, 8'd15, 3'd2, INCR, 8'h20, 32'h1000, 4'hF, 0, wf, wl);
        pushIncr(32'h1000, 16);
        fork
            writeBurst(16'h0800, 8'd15, 3'd2, INCR, 8'h21, 32'h2000, 4'hF, 10, wf, wl);
            readBurst(16'h0400, 8'd15, 3'd2, INCR, 8'h22, 1'b0, rf, rl);
        join
        checkOutput("write_beats_one_per_cycle", 64'(wl - wf), 64'd15);
        checkOutput("read_beats_one_per_cycle", 64'(rl - rf), 64'd15);
        pushIncr(32'h2000, 16);
        readBurst(16'h0800, 8'd15, 3'd2, INCR, 8'h23, 1'b0, rf, rl);

        $display("[TB] reset during read burst");
        s_axi_arid = 8'h30; s_axi_araddr = 16'h0100; s_axi_arlen = 8'd15;
        s_axi_arsize = 3'd2; s_axi_arburst = INCR; s_axi_arvalid = 1'b1;
        guard = 0;
        while (s_axi_arready !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        beats = 0; guard = 0;
        while (beats < 5 && guard < 100) begin
            if (s_axi_rvalid === 1'b1) begin
                checkOutput("pre_reset_rdata", 64'(s_axi_rdata), 64'(beats));
                beats++;
            end
            @(posedge clk); #1; guard++;
        end
        checkOutput("pre_reset_beats", 64'(beats), 64'd5);
        checkOutput("rvalid_on_beat5", 64'(s_axi_rvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rvalid_drops_in_reset", 64'(s_axi_rvalid), 64'd0);
        checkOutput("arready_low_in_reset", 64'(s_axi_arready), 64'd0);
        s_axi_rready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("arready_low_before_edge", 64'(s_axi_arready), 64'd0);
        @(posedge clk); #1;
        checkOutput("arready_after_release", 64'(s_axi_arready), 64'd1);
        checkOutput("rvalid_idle_after_release", 64'(s_axi_rvalid), 64'd0);
        pushIncr(32'd0, 4);
        readBurst(16'h0100, 8'd3, 3'd2, INCR, 8'h31, 1'b0, rf, rl);

        checkOutput("scoreboard_drained", 64'(rd_expect_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
